// File: rtl/cnl_job_host_ctrl.sv
// Host-side initiator for the quad job protocol with a 2-entry result skid buffer.
// Optional watchdog enabled by defining CNL_JOB_TIMEOUT_EN.
module cnl_job_host_ctrl #(
    parameter int C_PARAM_WIDTH    = 128,
    parameter int C_RESULT_WIDTH   = 16,
    parameter int C_CNT_WIDTH      = 32,
    parameter int C_TIMEOUT_CYCLES = 1048576
) (
    input  logic                      clk_if,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [C_PARAM_WIDTH-1:0]  cmd_params,
    input  logic [C_CNT_WIDTH-1:0]    cmd_num_results,
    output logic                      job_start,
    input  logic                      job_accept,
    output logic [C_PARAM_WIDTH-1:0]  job_parameters,
    input  logic                      job_fetch_request,
    output logic                      job_fetch_ack,
    output logic                      job_fetch_complete,
    output logic                      fetch_go,
    input  logic                      fetch_done,
    input  logic                      job_complete,
    output logic                      job_complete_ack,
    input  logic                      result_valid,
    output logic                      result_accept,
    input  logic [C_RESULT_WIDTH-1:0] result_data,
    output logic                      res_out_valid,
    input  logic                      res_out_ready,
    output logic [C_RESULT_WIDTH-1:0] res_out_data,
    output logic [C_CNT_WIDTH-1:0]    result_count,
    output logic                      job_done,
    output logic                      count_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_FACK  = 3'd3,
        S_FWAIT = 3'd4,
        S_FCMP  = 3'd5,
        S_CACK  = 3'd6
    } state_t;

    state_t                    state_r;
    logic                      cmd_ready_r, job_start_r, job_fetch_ack_r, fetch_go_r;
    logic                      job_fetch_complete_r, job_complete_ack_r, job_done_r, count_err_r;
    logic [C_PARAM_WIDTH-1:0]  job_params_r;
    logic [C_CNT_WIDTH-1:0]    expect_r, result_count_r, count_next_s;
    logic                      result_accept_r, head_valid_r, skid_valid_r;
    logic [C_RESULT_WIDTH-1:0] head_data_r, skid_data_r;
    logic                      push_s, pop_s, cmd_fire_s, timeout_s;
    logic [1:0]                occ_s, occ_next_s;

    assign push_s     = result_valid & result_accept_r;
    assign pop_s      = head_valid_r & res_out_ready;
    assign cmd_fire_s = cmd_valid & cmd_ready_r;

    // Next result count: one per push, saturating at all-ones
    always_comb begin
        count_next_s = result_count_r;
        if (push_s && (result_count_r != {C_CNT_WIDTH{1'b1}})) begin
            count_next_s = result_count_r + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = result_count_r;
        end
    end

    // Buffer occupancy after this cycle's push/pop
    always_comb begin
        occ_s      = {1'b0, head_valid_r} + {1'b0, skid_valid_r};
        occ_next_s = occ_s + {1'b0, push_s} - {1'b0, pop_s};
    end

`ifdef CNL_JOB_TIMEOUT_EN
    localparam int C_WD_WIDTH = $clog2(C_TIMEOUT_CYCLES + 1);
    state_t                prev_state_r;
    logic [C_WD_WIDTH-1:0] wd_r, dwell_s;
    logic                  watched_s;

    // Dwell time in the current state, including this cycle
    always_comb begin
        watched_s = (state_r == S_START) || (state_r == S_FWAIT) || (state_r == S_CACK);
        if (state_r == prev_state_r) begin
            dwell_s = wd_r + C_WD_WIDTH'(1);
        end else begin
            dwell_s = C_WD_WIDTH'(1);
        end
        timeout_s = watched_s && (dwell_s >= C_WD_WIDTH'(C_TIMEOUT_CYCLES));
    end

    // Watchdog counter, restarted whenever the FSM changes state
    always_ff @(posedge clk_if) begin
        if (rst) begin
            prev_state_r <= S_IDLE;
            wd_r         <= {C_WD_WIDTH{1'b0}};
        end else begin
            prev_state_r <= state_r;
            wd_r         <= watched_s ? dwell_s : {C_WD_WIDTH{1'b0}};
        end
    end
`else
    assign timeout_s = 1'b0 & (C_TIMEOUT_CYCLES < 0);
`endif

    // Result counter, cleared when a new job command is taken
    always_ff @(posedge clk_if) begin
        if (rst || cmd_fire_s) begin
            result_count_r <= {C_CNT_WIDTH{1'b0}};
        end else begin
            result_count_r <= count_next_s;
        end
    end

    // Two-entry skid buffer: head register drives the output, skid catches overflow
    always_ff @(posedge clk_if) begin
        if (rst) begin
            head_valid_r    <= 1'b0;
            skid_valid_r    <= 1'b0;
            head_data_r     <= {C_RESULT_WIDTH{1'b0}};
            skid_data_r     <= {C_RESULT_WIDTH{1'b0}};
            result_accept_r <= 1'b0;
        end else begin
            result_accept_r <= (occ_next_s != 2'd2);
            case ({head_valid_r, skid_valid_r})
                2'b00: begin
                    if (push_s) begin
                        head_data_r  <= result_data;
                        head_valid_r <= 1'b1;
                    end
                end
                2'b10: begin
                    if (push_s && pop_s) begin
                        head_data_r <= result_data;
                    end else if (pop_s) begin
                        head_valid_r <= 1'b0;
                    end else if (push_s) begin
                        skid_data_r  <= result_data;
                        skid_valid_r <= 1'b1;
                    end
                end
                2'b11: begin
                    if (pop_s) begin
                        head_data_r  <= skid_data_r;
                        skid_valid_r <= 1'b0;
                    end
                end
                default: begin
                    head_data_r  <= skid_data_r;
                    head_valid_r <= skid_valid_r;
                    skid_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Job protocol FSM with registered handshake outputs
    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_r              <= S_IDLE;
            cmd_ready_r          <= 1'b0;
            job_start_r          <= 1'b0;
            job_params_r         <= {C_PARAM_WIDTH{1'b0}};
            expect_r             <= {C_CNT_WIDTH{1'b0}};
            job_fetch_ack_r      <= 1'b0;
            fetch_go_r           <= 1'b0;
            job_fetch_complete_r <= 1'b0;
            job_complete_ack_r   <= 1'b0;
            job_done_r           <= 1'b0;
            count_err_r          <= 1'b0;
        end else begin
            job_done_r <= 1'b0;
            if (push_s && (state_r == S_IDLE)) begin
                count_err_r <= 1'b1;
            end
            if (timeout_s) begin
                state_r              <= S_IDLE;
                cmd_ready_r          <= 1'b1;
                job_start_r          <= 1'b0;
                job_fetch_ack_r      <= 1'b0;
                fetch_go_r           <= 1'b0;
                job_fetch_complete_r <= 1'b0;
                job_complete_ack_r   <= 1'b0;
                job_done_r           <= 1'b1;
                count_err_r          <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (cmd_fire_s) begin
                            job_params_r <= cmd_params;
                            expect_r     <= cmd_num_results;
                            cmd_ready_r  <= 1'b0;
                            job_start_r  <= 1'b1;
                            state_r      <= S_START;
                        end else begin
                            cmd_ready_r <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (job_accept) begin
                            job_start_r <= 1'b0;
                            state_r     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // A fetch request wins over a simultaneous job completion
                        if (job_fetch_request) begin
                            job_fetch_ack_r <= 1'b1;
                            fetch_go_r      <= 1'b1;
                            state_r         <= S_FACK;
                        end else if (job_complete) begin
                            job_complete_ack_r <= 1'b1;
                            state_r            <= S_CACK;
                        end
                    end
                    S_FACK: begin
                        job_fetch_ack_r <= 1'b0;
                        fetch_go_r      <= 1'b0;
                        state_r         <= S_FWAIT;
                    end
                    S_FWAIT: begin
                        if (fetch_done) begin
                            job_fetch_complete_r <= 1'b1;
                            state_r              <= S_FCMP;
                        end
                    end
                    S_FCMP: begin
                        job_fetch_complete_r <= 1'b0;
                        state_r              <= S_RUN;
                    end
                    S_CACK: begin
                        if (!job_complete) begin
                            job_complete_ack_r <= 1'b0;
                            job_done_r         <= 1'b1;
                            cmd_ready_r        <= 1'b1;
                            state_r            <= S_IDLE;
                            if (count_next_s != expect_r) begin
                                count_err_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r              <= S_IDLE;
                        cmd_ready_r          <= 1'b0;
                        job_start_r          <= 1'b0;
                        job_fetch_ack_r      <= 1'b0;
                        fetch_go_r           <= 1'b0;
                        job_fetch_complete_r <= 1'b0;
                        job_complete_ack_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready          = cmd_ready_r;
    assign job_start          = job_start_r;
    assign job_parameters     = job_params_r;
    assign job_fetch_ack      = job_fetch_ack_r;
    assign fetch_go           = fetch_go_r;
    assign job_fetch_complete = job_fetch_complete_r;
    assign job_complete_ack   = job_complete_ack_r;
    assign result_accept      = result_accept_r;
    assign res_out_valid      = head_valid_r;
    assign res_out_data       = head_data_r;
    assign result_count       = result_count_r;
    assign job_done           = job_done_r;
    assign count_err          = count_err_r;

endmodule

// File: tb/tb_cnl_job_host_ctrl.sv
// Scoreboard bench for cnl_job_host_ctrl: quad/DMA/downstream models driven from tasks.
module tb_cnl_job_host_ctrl;
    localparam int PW = 128;
    localparam int RW = 16;
    localparam int CW = 32;

    logic          clk_if = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [PW-1:0] cmd_params = '0;
    logic [CW-1:0] cmd_num_results = '0;
    logic          job_start, job_accept = 1'b0;
    logic [PW-1:0] job_parameters;
    logic          job_fetch_request = 1'b0, job_fetch_ack, job_fetch_complete;
    logic          fetch_go, fetch_done = 1'b0;
    logic          job_complete = 1'b0, job_complete_ack;
    logic          result_valid = 1'b0, result_accept;
    logic [RW-1:0] result_data = '0;
    logic          res_out_valid, res_out_ready = 1'b1;
    logic [RW-1:0] res_out_data;
    logic [CW-1:0] result_count;
    logic          job_done, count_err;

    int n_total = 0;
    int n_bad   = 0;
    int ack_cyc = 0, go_cyc = 0, fcmp_cyc = 0, done_cyc = 0;
    logic [RW-1:0] sb[$];

    always #5 clk_if = ~clk_if;

    cnl_job_host_ctrl #(.C_TIMEOUT_CYCLES(16)) dut (
        .clk_if(clk_if), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_params(cmd_params), .cmd_num_results(cmd_num_results),
        .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete),
        .fetch_go(fetch_go), .fetch_done(fetch_done),
        .job_complete(job_complete), .job_complete_ack(job_complete_ack),
        .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
        .res_out_valid(res_out_valid), .res_out_ready(res_out_ready), .res_out_data(res_out_data),
        .result_count(result_count), .job_done(job_done), .count_err(count_err)
    );

    task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    // Pulse counters and scoreboard pop, sampled mid-cycle
    always @(negedge clk_if) begin
        if (!rst) begin
            if (job_fetch_ack)      ack_cyc++;
            if (fetch_go)           go_cyc++;
            if (job_fetch_complete) fcmp_cyc++;
            if (job_done)           done_cyc++;
            if (res_out_valid && res_out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", PW'(res_out_valid), PW'(1'b0));
                end else begin
                    check_eq("out_data", PW'(res_out_data), PW'(sb.pop_front()));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd_ready"}, PW'(cmd_ready), '0);
        check_eq({tag, "_job_start"}, PW'(job_start), '0);
        check_eq({tag, "_params"}, job_parameters, '0);
        check_eq({tag, "_fack"}, PW'(job_fetch_ack), '0);
        check_eq({tag, "_fgo"}, PW'(fetch_go), '0);
        check_eq({tag, "_fcmp"}, PW'(job_fetch_complete), '0);
        check_eq({tag, "_cack"}, PW'(job_complete_ack), '0);
        check_eq({tag, "_accept"}, PW'(result_accept), '0);
        check_eq({tag, "_outv"}, PW'(res_out_valid), '0);
        check_eq({tag, "_count"}, PW'(result_count), '0);
        check_eq({tag, "_done"}, PW'(job_done), '0);
        check_eq({tag, "_err"}, PW'(count_err), '0);
    endtask

    task automatic issue_cmd(input logic [PW-1:0] p, input logic [CW-1:0] num);
        int n = 0;
        cmd_params = p;
        cmd_num_results = num;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("cmd_ready_wait", PW'(cmd_ready), PW'(1'b1));
        tick();
        cmd_valid = 1'b0;
        check_eq("job_start_set", PW'(job_start), PW'(1'b1));
        check_eq("cmd_ready_low", PW'(cmd_ready), '0);
        check_eq("job_params", job_parameters, p);
    endtask

    task automatic accept_job(input int delay);
        repeat (delay) tick();
        check_eq("job_start_held", PW'(job_start), PW'(1'b1));
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        check_eq("job_start_drop", PW'(job_start), '0);
    endtask

    task automatic send_result(input logic [RW-1:0] d);
        int n = 0;
        result_valid = 1'b1;
        result_data = d;
        while (!result_accept && n < 50) begin
            tick();
            n++;
        end
        check_eq("accept_wait", PW'(result_accept), PW'(1'b1));
        sb.push_back(d);
        tick();
        result_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check_eq("drain", PW'(sb.size()), '0);
    endtask

    task automatic do_fetch();
        int n = 0;
        job_fetch_request = 1'b1;
        while (!job_fetch_ack && n < 50) begin
            tick();
            n++;
        end
        check_eq("fack_set", PW'(job_fetch_ack), PW'(1'b1));
        check_eq("fgo_set", PW'(fetch_go), PW'(1'b1));
        job_fetch_request = 1'b0;
        repeat (5) begin
            tick();
            check_eq("fcmp_early", PW'(job_fetch_complete), '0);
        end
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        check_eq("fcmp_set", PW'(job_fetch_complete), PW'(1'b1));
        tick();
        check_eq("fcmp_drop", PW'(job_fetch_complete), '0);
    endtask

    task automatic complete_job(input int hold);
        int n = 0;
        job_complete = 1'b1;
        tick();
        while (!job_complete_ack && n < 50) begin
            tick();
            n++;
        end
        check_eq("cack_set", PW'(job_complete_ack), PW'(1'b1));
        repeat (hold) begin
            tick();
            check_eq("cack_held", PW'(job_complete_ack), PW'(1'b1));
            check_eq("done_early", PW'(job_done), '0);
        end
        job_complete = 1'b0;
        tick();
        check_eq("job_done_pulse", PW'(job_done), PW'(1'b1));
        check_eq("cack_drop", PW'(job_complete_ack), '0);
        tick();
        check_eq("job_done_end", PW'(job_done), '0);
        check_eq("cmd_ready_idle", PW'(cmd_ready), PW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", PW'(cmd_ready), PW'(1'b1));
        check_eq("post_rst_accept", PW'(result_accept), PW'(1'b1));

        // Basic job
        done_cyc = 0;
        issue_cmd(128'h0123_4567_89ab_cdef_0011_2233_4455_66a5, 32'd4);
        accept_job(3);
        for (int i = 0; i < 4; i++) send_result(16'h0011 + 16'(i));
        drain();
        complete_job(2);
        check_eq("basic_count", PW'(result_count), PW'(32'd4));
        check_eq("basic_err", PW'(count_err), '0);
        check_eq("basic_done_cnt", PW'(done_cyc), PW'(1));
        check_eq("basic_params_stable", job_parameters, 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5);

        // Two fetches
        ack_cyc = 0; go_cyc = 0; fcmp_cyc = 0;
        issue_cmd(128'h2, 32'd0);
        accept_job(1);
        do_fetch();
        do_fetch();
        complete_job(0);
        check_eq("fetch_ack_cyc", PW'(ack_cyc), PW'(2));
        check_eq("fetch_go_cyc", PW'(go_cyc), PW'(2));
        check_eq("fetch_cmp_cyc", PW'(fcmp_cyc), PW'(2));
        check_eq("fetch_err", PW'(count_err), '0);

        // Backpressure
        issue_cmd(128'h3, 32'd5);
        accept_job(0);
        res_out_ready = 1'b0;
        send_result(16'h0100);
        check_eq("bp_accept_1", PW'(result_accept), PW'(1'b1));
        send_result(16'h0101);
        check_eq("bp_accept_2", PW'(result_accept), '0);
        fork
            for (int i = 2; i < 5; i++) send_result(16'h0100 + 16'(i));
            begin
                repeat (4) tick();
                res_out_ready = 1'b1;
            end
        join
        drain();
        complete_job(0);
        check_eq("bp_count", PW'(result_count), PW'(32'd5));
        check_eq("bp_err", PW'(count_err), '0);

        // Count mismatch, then a good job keeps the sticky flag
        issue_cmd(128'h4, 32'd3);
        accept_job(0);
        send_result(16'h0200);
        send_result(16'h0201);
        drain();
        complete_job(0);
        check_eq("mm_count", PW'(result_count), PW'(32'd2));
        check_eq("mm_err", PW'(count_err), PW'(1'b1));
        issue_cmd(128'h5, 32'd1);
        accept_job(0);
        send_result(16'h0300);
        drain();
        complete_job(0);
        check_eq("good_count", PW'(result_count), PW'(32'd1));
        check_eq("sticky_err", PW'(count_err), PW'(1'b1));

        // Fetch request and job completion in the same RUN cycle
        issue_cmd(128'h6, 32'd0);
        accept_job(0);
        job_fetch_request = 1'b1;
        job_complete = 1'b1;
        tick();
        check_eq("sim_fack", PW'(job_fetch_ack), PW'(1'b1));
        check_eq("sim_cack_0", PW'(job_complete_ack), '0);
        job_fetch_request = 1'b0;
        tick();
        check_eq("sim_cack_fwait", PW'(job_complete_ack), '0);
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        check_eq("sim_fcmp", PW'(job_fetch_complete), PW'(1'b1));
        check_eq("sim_cack_fcmp", PW'(job_complete_ack), '0);
        tick();
        check_eq("sim_cack_run", PW'(job_complete_ack), '0);
        tick();
        check_eq("sim_cack_set", PW'(job_complete_ack), PW'(1'b1));
        job_complete = 1'b0;
        tick();
        check_eq("sim_done", PW'(job_done), PW'(1'b1));
        tick();

        // Reset while waiting for fetch_done
        issue_cmd(128'h7, 32'd0);
        accept_job(0);
        job_fetch_request = 1'b1;
        tick();
        check_eq("rst_fack", PW'(job_fetch_ack), PW'(1'b1));
        job_fetch_request = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        check_eq("midrst_ready", PW'(cmd_ready), PW'(1'b1));
        check_eq("midrst_fcmp", PW'(job_fetch_complete), '0);

        // Result pushed while idle flags an error
        send_result(16'h0bad);
        check_eq("idle_push_err", PW'(count_err), PW'(1'b1));
        drain();

`ifdef CNL_JOB_TIMEOUT_EN
        begin
            int n = 0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            done_cyc = 0;
            issue_cmd(128'h8, 32'd0);
            while (job_start && n < 100) begin
                tick();
                n++;
            end
            check_eq("wd_cycles", PW'(n), PW'(16));
            check_eq("wd_done", PW'(job_done), PW'(1'b1));
            check_eq("wd_err", PW'(count_err), PW'(1'b1));
            tick();
            check_eq("wd_ready", PW'(cmd_ready), PW'(1'b1));
        end
`endif

        repeat (3) tick();
        check_eq("sb_empty", PW'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/cnl_job_host_ctrl.md
Name: cnl_job_host_ctrl

Overview:
- Host-side initiator for the quad job protocol; drives what a testbench driver drives today: job start, fetch acknowledge/complete and job-complete acknowledge.
- Collects the quad result stream into a 2-entry skid buffer and forwards it downstream, counting results against a per-job expected count.
- Sits between the layer scheduler/DMA and cnn_layer_accel_quad, in the clk_if domain.

Parameters:
- C_PARAM_WIDTH, 128, width of job_parameters / cmd_params
- C_RESULT_WIDTH, 16, width of result_data
- C_CNT_WIDTH, 32, width of result counters
- C_TIMEOUT_CYCLES, 1048576, watchdog limit (used only with the optional feature)

Ports:
- clk_if in 1: interface clock; all logic is on this clock.
- rst in 1: synchronous, active-high reset.
- cmd_valid in 1 / cmd_ready out 1: job command handshake from the scheduler.
- cmd_params in C_PARAM_WIDTH: job parameters.
- cmd_num_results in C_CNT_WIDTH: expected number of results for the job.
- job_start out 1 / job_accept in 1 / job_parameters out C_PARAM_WIDTH: job issue to the quad.
- job_fetch_request in 1 / job_fetch_ack out 1 / job_fetch_complete out 1: fetch protocol.
- fetch_go out 1 / fetch_done in 1: DMA trigger and completion.
- job_complete in 1 / job_complete_ack out 1: job completion protocol.
- result_valid in 1 / result_accept out 1 / result_data in C_RESULT_WIDTH: quad result stream.
- res_out_valid out 1 / res_out_ready in 1 / res_out_data out C_RESULT_WIDTH: downstream result stream.
- result_count out C_CNT_WIDTH: results received this job.
- job_done out 1: one-cycle pulse per finished job.
- count_err out 1: sticky count-mismatch flag.

Behaviour:
- Reset (synchronous, takes effect on the clk_if edge with rst=1): every output is 0; job_parameters=0; FSM=IDLE; skid buffer empty; counters 0. The exception is cmd_ready, which is 1 in IDLE once rst deasserts. Reset mid-job abandons the job with no acks issued.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch cmd_params into job_parameters and cmd_num_results into an expect register;
  - clear result_count;
  - go to START.
- START: job_start=1, held until a cycle with job_accept=1; then go to RUN. job_parameters is stable from START until the next command.
- RUN: waits for fetch requests or job completion.
  - job_fetch_request=1 -> FACK: job_fetch_ack=1 and fetch_go=1 for exactly one cycle -> FWAIT.
  - job_complete=1 (and no fetch in progress) -> CACK.
  - If both arrive in the same cycle, the fetch has priority.
- FWAIT: wait for fetch_done=1 -> FCMP: job_fetch_complete=1 for one cycle -> RUN. Any number of fetches per job is supported.
- CACK: job_complete_ack=1, held while job_complete=1. When job_complete drops:
  - pulse job_done;
  - set count_err if result_count != expect;
  - go to IDLE.
  - Results arriving during CACK are still counted before the compare.
- Result path:
  - result_accept = !buffer_full, independent of FSM state.
  - Push when result_valid&result_accept; pop when res_out_valid&res_out_ready. Push and pop in the same cycle leaves occupancy unchanged.
  - FIFO order is preserved; res_out_data is registered, so latency is 1 cycle when the buffer is empty.
  - result_count increments per push and saturates at all-ones.
  - A push in IDLE sets count_err.
- count_err is sticky until rst.

Optional Feature:
- CNL_JOB_TIMEOUT_EN defined: a watchdog counter runs in START, FWAIT and CACK.
  - It clears on every state change.
  - On reaching C_TIMEOUT_CYCLES it sets count_err, pulses job_done, and forces the FSM to IDLE with all protocol outputs deasserted.
- Undefined: no watchdog logic; the FSM waits indefinitely.

Test Plan:
- Basic job: cmd with num_results=4; quad accepts 3 cycles after job_start; 4 results 0x0011..0x0014; job_complete asserted -> job_complete_ack held while asserted, job_done pulses once, result_count=4, count_err=0, res_out_data sequence 0x0011..0x0014.
- Two fetches: job_fetch_request twice; fetch_done 5 cycles after each fetch_go -> exactly 2 one-cycle job_fetch_ack pulses, 2 fetch_go pulses, 2 job_fetch_complete pulses, each one cycle after its fetch_done.
- Backpressure: res_out_ready=0 during 5 results -> result_accept drops after 2 pushes. Releasing res_out_ready drains all 5 in order with none lost; result_count=5.
- Mismatch: num_results=3, only 2 results before job_complete -> count_err=1 at job_done and stays 1 through the next good job.
- Simultaneous events: job_fetch_request and job_complete in the same RUN cycle -> FACK first, CACK only after FCMP. Separately, rst for 1 cycle during FWAIT -> all outputs 0 and cmd_ready=1 on the next cycle.
- With CNL_JOB_TIMEOUT_EN and C_TIMEOUT_CYCLES=16: job_accept never asserted -> after 16 cycles in START, job_start drops, job_done pulses and count_err=1.
